// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs fixed-latency mult/div, serves mfhi/mflo.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu accumulating into {hi,lo}.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_ok_q, pend_ok_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          is_mul, is_div, is_signed, is_acc, is_sub, launch_op;
    logic [63:0]   op_a, op_b, product, acc_result;
    logic [31:0]   a_mag, b_mag, quo_mag, rem_mag, quo, rem;
    logic [63:0]   result;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_acc    = 1'b0;
        is_sub    = 1'b0;
        case (mdu_op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
        launch_op = is_mul | is_div;
    end

    assign busy  = (cnt_q != '0);
    assign start = launch_op && !req && !busy;

    // Sign-extending only for signed ops lets one 64-bit multiplier serve both flavours.
    assign op_a    = {{32{is_signed & rs_data[31]}}, rs_data};
    assign op_b    = {{32{is_signed & rt_data[31]}}, rt_data};
    assign product = op_a * op_b;

    assign acc_result = is_sub ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);

    // Magnitude divider with sign fix-up; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign a_mag   = (is_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign b_mag   = (is_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    assign quo_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign rem_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo     = (is_signed && (rs_data[31] ^ rt_data[31])) ? (32'd0 - quo_mag) : quo_mag;
    assign rem     = (is_signed && rs_data[31]) ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        result = product;
        if (is_div) begin
            result = {rem, quo};
        end else if (is_acc) begin
            result = acc_result;
        end
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        cnt_d     = cnt_q;
        if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && pend_ok_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end
        if (start) begin
            pend_hi_d = result[63:32];
            pend_lo_d = result[31:0];
            pend_ok_d = !(is_div && rt_data == 32'd0);
            cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
        if (!req && !busy) begin
            if (mdu_op == OP_MTHI) hi_d = rs_data;
            if (mdu_op == OP_MTLO) lo_d = rs_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        rd_data = 32'd0;
        if (mdu_op == OP_MFHI) rd_data = hi_q;
        if (mdu_op == OP_MFLO) rd_data = lo_q;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} queued at launch, checked when busy falls.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data, rt_data;
    logic        req;
    logic        start, busy;
    logic [31:0] hi, lo, rd_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .rs_data(rs_data), .rt_data(rt_data),
        .req(req), .start(start), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [31:0] val);
        mdu_op = op; rs_data = val;
        step();
        mdu_op = 4'd0;
    endtask

    task automatic launch(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_hilo);
        mdu_op = op; rs_data = a; rt_data = b;
        #1;
        check({tag, " start"}, 64'(start), 64'd1);
        exp_q.push_back(exp_hilo);
        step();
        mdu_op = 4'd0;
    endtask

    task automatic drain(input string tag, input int n);
        int cnt = 0;
        logic [63:0] e;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        check({tag, " busy cycles"}, 64'(cnt), 64'(n));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " hilo"}, {hi, lo}, e);
        end else begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end
    endtask

    // Signed product built from the unsigned one by subtracting the two's-complement correction terms.
    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (a[31]) p = p - {b, 32'd0};
        if (b[31]) p = p - {a, 32'd0};
        return p;
    endfunction

    initial begin
        reset = 1'b1; mdu_op = 4'd0; rs_data = '0; rt_data = '0; req = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset start", 64'(start), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);

        launch("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult busy cycle1", 64'(busy), 64'd1);
        drain("mult -2*3", 5);

        launch("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        drain("multu", 5);

        launch("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        drain("div -7/2", 10);

        launch("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        drain("div ovf", 10);

        launch("divu 100/7", 4'd4, 32'd100, 32'd7, {32'd2, 32'd14});
        drain("divu 100/7", 10);

        write_reg(4'd7, 32'h1234);
        write_reg(4'd8, 32'h5678);
        check("mthi", 64'(hi), 64'h1234);
        check("mtlo", 64'(lo), 64'h5678);
        launch("divu by 0", 4'd4, 32'd99, 32'd0, {32'h1234, 32'h5678});
        drain("divu by 0", 10);
        mdu_op = 4'd5; #1;
        check("mfhi", 64'(rd_data), 64'h1234);
        mdu_op = 4'd6; #1;
        check("mflo", 64'(rd_data), 64'h5678);
        mdu_op = 4'd0; #1;
        check("rd_data idle", 64'(rd_data), 64'd0);

        mdu_op = 4'd1; rs_data = 32'd5; rt_data = 32'd7; req = 1'b1; #1;
        check("req start", 64'(start), 64'd0);
        step();
        mdu_op = 4'd0; req = 1'b0; #1;
        check("req busy", 64'(busy), 64'd0);
        check("req hilo", {hi, lo}, {32'h1234, 32'h5678});

        launch("div req inflight", 4'd3, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2});
        mdu_op = 4'd7; rs_data = 32'hDEAD; req = 1'b1;
        step();
        mdu_op = 4'd1; req = 1'b0; #1;
        check("op while busy start", 64'(start), 64'd0);
        step();
        mdu_op = 4'd0;
        drain("div req inflight", 8);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (i[0]) launch("rand multu", 4'd2, a, b, {32'd0, a} * {32'd0, b});
            else      launch("rand mult", 4'd1, a, b, smul(a, b));
            drain("rand mul", 5);
        end

        launch("div reset", 4'd3, 32'd50, 32'd3, {32'd2, 32'd16});
        step(); step();
        reset = 1'b1; #1;
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid hilo", {hi, lo}, 64'd0);
        void'(exp_q.pop_front());
        step();
        reset = 1'b0;
        step();
        check("post rst hilo", {hi, lo}, 64'd0);

`ifdef MDU_MADD_EN
        write_reg(4'd8, 32'hFFFF_FFFF);
        launch("madd", 4'd9, 32'd1, 32'd1, {32'd1, 32'd0});
        drain("madd", 5);
        launch("msub", 4'd11, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFA);
        drain("msub", 5);
        launch("maddu", 4'd10, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_FFFF_FFF8);
        drain("maddu", 5);
`else
        mdu_op = 4'd9; rs_data = 32'd1; rt_data = 32'd1; #1;
        check("madd off start", 64'(start), 64'd0);
        step();
        mdu_op = 4'd0;
        check("madd off busy", 64'(busy), 64'd0);
        check("madd off hilo", {hi, lo}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO registers and sits in the E stage of the 5-stage pipeline. It accepts the E-stage MDU opcode, launches mult/div operations, and holds busy for the fixed operation latency. It commits results to HI/LO and serves mfhi/mflo reads. Its start/busy outputs feed the hazard control unit's MDU stall term. The E-stage exception request suppresses launch and write side effects.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); must be >= 1
DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
mdu_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 madd/maddu/msub/msubu (optional), others none
rs_data  input  32  forwarded E-stage operand A
rt_data  input  32  forwarded E-stage operand B
req  input  1  exception/interrupt taken this cycle; E-stage instruction is cancelled
start  output  1  combinational: launch condition this cycle
busy  output  1  registered: operation in flight
hi  output  32  HI register
lo  output  32  LO register
rd_data  output  32  combinational: hi when mdu_op=5, lo when mdu_op=6, else 0

Behaviour:
- Reset values (async): hi=0, lo=0, busy=0, counter=0, pending result=0. start and rd_data follow their combinational definitions.
- start = (mdu_op in {1,2,3,4} or an enabled madd op) && !req && !busy.
- On an edge with start=1:
  - compute the 64-bit result from rs_data/rt_data and latch it into pending_hi/pending_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0).
  - Start in cycle t: busy=1 for cycles t+1 .. t+N.
  - The counter decrements each edge while nonzero.
  - On the edge where the counter goes 1->0, commit pending_hi/pending_lo to hi/lo.
  - New HI/LO values are visible in cycle t+N+1, when busy=0.
- Arithmetic rules:
  - mult: signed 32x32->64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32->64, same split.
  - div: signed; lo=quotient, hi=remainder, truncating toward zero; remainder takes the dividend's sign.
  - divu: unsigned; lo=quotient, hi=remainder.
  - div/divu with rt_data=0: the operation still occupies DIV_CYCLES, but hi/lo keep their prior values (commit suppressed).
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - take effect on the edge when mdu_op=7/8 && !req && !busy; write rs_data to hi/lo;
  - no busy period.
- mfhi/mflo: pure combinational read of the current hi/lo; no state change.
- req=1: no state change from the E-stage op (start=0, mthi/mtlo dropped). An operation already in flight is unaffected and completes and commits normally.
- MDU op presented while busy=1: ignored, no effect. The hazard control unit stalls such ops in D, so this case is defensive only.
- Same-cycle mthi/mtlo and commit cannot occur, because mthi/mtlo requires !busy.
- Reset asserted mid-operation: busy drops immediately, the pending result is discarded, and hi/lo become 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 9 madd and 11 msub form the signed product; ops 10 maddu and 12 msubu form the unsigned product.
  - The product is added to (madd/maddu) or subtracted from (msub/msubu) the 64-bit {hi,lo} value sampled at the start edge, modulo 2^64.
  - These ops use MULT_CYCLES latency and the same commit path as mult.
- Undefined: ops 9-12 decode as none (start=0, no effect).

Test Plan:
- After reset: mult rs=0xFFFFFFFE (-2), rt=3 -> start=1 in cycle 0; busy=1 in cycles 1-5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rt=0 after mthi 0x1234 and mtlo 0x5678 -> busy for 10 cycles, then hi=0x1234 and lo=0x5678 unchanged; mfhi gives rd_data=0x1234.
- mult with req=1 in the same cycle -> start=0, busy stays 0, hi/lo unchanged. Separately, req during an in-flight div -> div still commits.
- Reset pulsed at busy cycle 3 of a div -> busy=0 and hi=lo=0 immediately. With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd rs=1, rt=1 -> hi=1, lo=0.
